// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register-file write port
// among NREQ writeback requesters, with a registered write command and a
// saturating contention counter.
// Optional feature macro: WB_FWD_EN adds a two-port bypass check of the write
// currently presented to the register file (fwd_rs / fwd_hit / fwd_data).
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_wd,
  input  logic               stall,
  output logic               rf_we,
  output logic [AW-1:0]      rf_rd,
  output logic [DW-1:0]      rf_wd,
  output logic [2:0]         grant_id,
  output logic [CW-1:0]      contention
`ifdef WB_FWD_EN
  ,
  input  logic [2*AW-1:0]    fwd_rs,
  output logic [1:0]         fwd_hit,
  output logic [2*DW-1:0]    fwd_data
`endif
);

  logic [2:0]        ptr;
  logic [2*NREQ-1:0] rot;
  logic [2:0]        winner;
  logic [2:0]        winner_nxt;
  logic              any_valid;
  logic              xfer;
  logic [3:0]        nvalid;
  logic [AW-1:0]     sel_rd;
  logic [DW-1:0]     sel_wd;

  // Rotate valid bits so index 0 is the current pointer, then pick the first set bit.
  always_comb begin
    logic [3:0] sum;
    rot       = {req_valid, req_valid} >> ptr;
    winner    = 3'd0;
    any_valid = 1'b0;
    sum       = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_valid && rot[k]) begin
        any_valid = 1'b1;
        sum       = {1'b0, ptr} + 4'(k);
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        winner    = sum[2:0];
      end
    end
  end

  // Ready goes only to the winner, and only when the port is available.
  always_comb begin
    xfer       = any_valid & ~stall & ~rst;
    req_ready  = '0;
    sel_rd     = '0;
    sel_wd     = '0;
    winner_nxt = (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == 3'(i)) begin
        req_ready[i] = xfer;
        sel_rd       = req_rd[i*AW +: AW];
        sel_wd       = req_wd[i*DW +: DW];
      end
    end
  end

  // Number of requesters asking this cycle, for contention accounting.
  always_comb begin
    nvalid = 4'd0;
    for (int i = 0; i < NREQ; i++) nvalid = nvalid + {3'd0, req_valid[i]};
  end

  // Registered write command and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wd    <= '0;
      grant_id <= 3'd0;
      ptr      <= 3'd0;
    end else if (xfer) begin
      rf_we    <= |sel_rd;
      rf_rd    <= sel_rd;
      rf_wd    <= sel_wd;
      grant_id <= winner;
      ptr      <= winner_nxt;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Saturating count of cycles where two or more requesters compete for an open port.
  always_ff @(posedge clk) begin
    if (rst) begin
      contention <= '0;
    end else if (!stall && nvalid >= 4'd2 && contention != {CW{1'b1}}) begin
      contention <= contention + CW'(1);
    end
  end

`ifdef WB_FWD_EN
  // Bypass check of the write currently being presented to the register file.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int k = 0; k < 2; k++) begin
      fwd_hit[k] = rf_we & (rf_rd == fwd_rs[k*AW +: AW]);
      if (fwd_hit[k]) fwd_data[k*DW +: DW] = rf_wd;
    end
  end
`endif

endmodule
